// File: rtl/sect163r2_pt_mul_arb.sv
// Round-robin front end that shares one sect163r2 point-multiply core between
// several requesters, with a watchdog that recovers a hung core.
//
// state | meaning
// IDLE  | offer grant to the next valid requester, round-robin from rr_ptr
// ISSUE | pm_start pulse with the latched scalar on pm_d
// BUSY  | wait for pm_done; watchdog down-counter running
// RESP  | hold response until rsp_ready
module sect163r2_pt_mul_arb #(
  parameter int NumReq     = 4,
  parameter int IdW        = 2,
  parameter int TimeoutCyc = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [NumReq*163-1:0]   req_d,
  output logic [NumReq-1:0]       req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IdW-1:0]          rsp_id,
  output logic [162:0]            rsp_x,
  output logic [162:0]            rsp_y,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    pm_clr,
  output logic                    pm_start,
  output logic [162:0]            pm_d,
  input  logic                    pm_done,
  input  logic [162:0]            pm_x,
  input  logic [162:0]            pm_y
);

  localparam int CntW = $clog2(TimeoutCyc + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(TimeoutCyc - 1);
  localparam logic [IdW:0] NumW = (IdW + 1)'(NumReq);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [IdW-1:0]  rr_ptr, grant, grant_inc, id_q;
  logic [IdW:0]    arb_idx, inc_w;
  logic            found, accept, wd_fire;
  logic [CntW-1:0] wd_cnt;

  // Search rr_ptr, rr_ptr+1, ... wrapping at NumReq (need not be a power of 2).
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    arb_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      arb_idx = {1'b0, rr_ptr} + (IdW + 1)'(k);
      if (arb_idx >= NumW) arb_idx = arb_idx - NumW;
      if (!found && req_valid[arb_idx[IdW-1:0]]) begin
        found = 1'b1;
        grant = arb_idx[IdW-1:0];
      end
    end
    inc_w = {1'b0, grant} + (IdW + 1)'(1);
    if (inc_w >= NumW) inc_w = '0;
    grant_inc = inc_w[IdW-1:0];
  end

  assign accept = rst_n && !clr && (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    wd_fire   = 1'b0;
    unique case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = BUSY;
      BUSY: begin
        if (pm_done) begin
          state_nxt = RESP;
        end else if (wd_cnt == '0) begin
          wd_fire   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  assign pm_clr    = clr | wd_fire;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      id_q     <= '0;
      wd_cnt   <= '0;
      pm_start <= 1'b0;
      pm_d     <= '0;
      rsp_id   <= '0;
      rsp_x    <= '0;
      rsp_y    <= '0;
      rsp_err  <= 1'b0;
    end else if (clr) begin
      rr_ptr   <= '0;
      wd_cnt   <= '0;
      pm_start <= 1'b0;
      pm_d     <= '0;
      rsp_id   <= '0;
      rsp_x    <= '0;
      rsp_y    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      pm_start <= accept;
      pm_d     <= accept ? req_d[163*int'(grant) +: 163] : '0;
      if (accept) begin
        id_q   <= grant;
        rr_ptr <= grant_inc;
      end
      if (state == ISSUE)
        wd_cnt <= CntLoad;
      else if (state == BUSY && wd_cnt != '0)
        wd_cnt <= wd_cnt - CntW'(1);
      // A done on the terminal-count cycle wins over the abort.
      if (state == BUSY) begin
        if (pm_done) begin
          rsp_x   <= pm_x;
          rsp_y   <= pm_y;
          rsp_err <= 1'b0;
          rsp_id  <= id_q;
        end else if (wd_fire) begin
          rsp_x   <= '0;
          rsp_y   <= '0;
          rsp_err <= 1'b1;
          rsp_id  <= id_q;
        end
      end
    end
  end

endmodule

// File: doc/sect163r2_pt_mul_arb.md
Name: sect163r2_pt_mul_arb

Overview:
Shares one sect163r2_pt_mul core between NumReq independent requesters.
- Arbitration: round-robin over valid/ready request channels.
- Sequencing: latches the winner's scalar, pulses the core's start, and waits for done.
- Result return: passes x/y back on a single valid/ready response channel tagged with the requester id.
- Watchdog: recovers a hung core by clearing it and returning an error response.

Parameters:
NumReq, 4, number of requesters (2..16).
IdW, 2, width of rsp_id; must equal clog2(NumReq).
TimeoutCyc, 4096, maximum cycles from pm_start to pm_done before an abort.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; aborts everything
req_valid  in  NumReq  per-requester request valid
req_d  in  NumReq*163  scalars; requester i uses bits [163*i+162:163*i]
req_ready  out  NumReq  one-hot grant/accept
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IdW  index of the requester being answered
rsp_x  out  163  result x
rsp_y  out  163  result y
rsp_err  out  1  1 = watchdog abort; rsp_x and rsp_y are 0
busy  out  1  high in any state other than IDLE
pm_clr  out  1  to core clr
pm_start  out  1  to core start; one-cycle pulse
pm_d  out  163  to core d; valid while pm_start=1, 0 otherwise
pm_done  in  1  from core done
pm_x  in  163  from core x
pm_y  in  163  from core y

Behaviour:
- Reset state (rst_n=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, busy, pm_clr, pm_start, pm_d.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NumReq.
  - req_ready = onehot(grant), or 0 if no valid. req_ready is combinational from req_valid and rr_ptr, and is 0 outside IDLE.
  - On handshake: latch d_q=req_d slice, id_q=grant, rr_ptr<=(grant+1) mod NumReq; go to ISSUE.
- ISSUE (1 cycle):
  - pm_start=1 and pm_d=d_q, both registered outputs.
  - Clear the watchdog counter; go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - On the edge where pm_done=1: capture rsp_x=pm_x, rsp_y=pm_y, rsp_err=0, rsp_id=id_q; go to RESP.
  - Else if counter reaches TimeoutCyc-1: pm_clr=1 for one cycle; rsp_x=rsp_y=0, rsp_err=1, rsp_id=id_q; go to RESP.
  - A pm_done that coincides with the timeout cycle wins: normal result, no pm_clr.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On handshake: rsp_valid=0, go to IDLE.
  - No new request is accepted in the handshake cycle; the next accept is possible the following cycle.
- Latency: accept at cycle T -> pm_start at T+1 -> BUSY from T+2 -> rsp_valid at Dn+1, where Dn is the pm_done cycle.
- pm_done outside BUSY is ignored.
- clr (synchronous, highest priority after reset):
  - pm_clr = clr | watchdog_clr (combinational OR).
  - Next state IDLE, rr_ptr=0, rsp_valid=0, rsp_err=0, counter=0.
  - No response is issued for an in-flight request; requesters re-request.
- Fairness: a requester holding valid is served within NumReq grants.
- Requester protocol: req_d must stay stable while req_valid=1. Dropping valid before ready is allowed (no grant).
- Reset mid-operation: immediate return to the reset state; the core is reset by its own rst_n.

Test Plan:
1. Single request: req_valid=4'b0001, d=1 -> accept, pm_start one cycle later with pm_d=1. Core returns generator G (x=3f0eba16286a2d57ea0991168d4994637e8343e36, y=0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1) -> rsp_id=0, rsp_err=0, rsp_x/rsp_y equal G; rsp_valid held 3 cycles while rsp_ready=0.
2. All four valid simultaneously, rr_ptr=0 -> service order 0,1,2,3. Then hold req_valid[1] and [3] -> grant order 1,3,1,3.
3. Back-to-back: rsp_ready tied 1 and req_valid[2] held -> next accept the cycle after the response handshake, never the same cycle. Per-operation overhead is 3 cycles beyond core latency.
4. Watchdog: TimeoutCyc=16, core stub never asserts done -> pm_clr pulses exactly 16 cycles after pm_start; response has rsp_err=1, rsp_x=rsp_y=0. A follow-up request then completes normally.
5. Edge cases:
   - pm_done asserted exactly on the timeout cycle -> normal result, rsp_err=0, no pm_clr.
   - pm_done pulse while IDLE -> no response.
6. Aborts:
   - clr pulsed in BUSY -> pm_clr same cycle, state IDLE, no rsp_valid, rr_ptr=0.
   - rst_n dropped mid-RESP -> all outputs 0 asynchronously.
